// File: rtl/weight_rd_arbiter_pkg.sv
// Shared types and defaults for the weight read-channel arbiter.
package weight_rd_arbiter_pkg;

    localparam int QZ_DEF     = 16;
    localparam int DATA_W_DEF = QZ_DEF * 4;
    localparam int ADDR_W_DEF = 20;
    localparam int LEN_W_DEF  = 10;

    localparam int REQ_AH = 0;
    localparam int REQ_FC = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER,
        ST_GAP
    } arb_state_e;

endpackage

// File: rtl/weight_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick; ptr_i names the requester that wins a tie.
module rr_arb2
    import weight_rd_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i[REQ_AH] && req_i[REQ_FC]) begin
            gnt_o        = 2'b00;
            gnt_o[ptr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/weight_rd_arbiter.sv
// Shares the weight-fetch read channel between the AH and FC engines,
// one burst at a time, with round-robin tie-breaking.
module weight_rd_arbiter
    import weight_rd_arbiter_pkg::*;
#(
    parameter int QZ     = QZ_DEF,
    parameter int DATA_W = QZ * 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ah,
    input  logic [ADDR_W-1:0] addr_ah,
    input  logic [LEN_W-1:0]  len_ah,
    input  logic              req_fc,
    input  logic [ADDR_W-1:0] addr_fc,
    input  logic [LEN_W-1:0]  len_fc,
    output logic              gnt_ah,
    output logic              gnt_fc,
    output logic              done_ah,
    output logic              done_fc,
    output logic              rd_valid_ah,
    output logic              rd_valid_fc,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              err_stray
);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [1:0]        pick;
    logic [LEN_W-1:0]  pick_len;

    rr_arb2 u_rr_arb2 (
        .req_i ({req_fc, req_ah}),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    assign pick_len = pick[REQ_FC] ? len_fc : len_ah;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        cmd_valid_d = cmd_valid_q;
        done_d      = 2'b00;
        vld_d       = 2'b00;
        data_d      = data_q;
        err_d       = err_q | (rd_valid && (state_q != ST_XFER));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|pick) begin
                    gnt_d       = pick;
                    addr_d      = pick[REQ_FC] ? addr_fc : addr_ah;
                    len_d       = pick_len;
                    // A zero-length burst never reaches the fetch engine.
                    cmd_valid_d = (pick_len != '0);
                    state_d     = ST_CMD;
                end
            end
            ST_CMD: begin
                if (len_q == '0) begin
                    done_d  = gnt_q;
                    state_d = ST_GAP;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rd_valid) begin
                    vld_d  = gnt_q;
                    data_d = rd_data;
                    cnt_d  = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        done_d  = gnt_q;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // Tie priority goes to whoever was not just served.
                ptr_d   = gnt_q[REQ_AH];
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 2'b00;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 2'b00;
            vld_q       <= 2'b00;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign gnt_ah      = gnt_q[REQ_AH];
    assign gnt_fc      = gnt_q[REQ_FC];
    assign done_ah     = done_q[REQ_AH];
    assign done_fc     = done_q[REQ_FC];
    assign rd_valid_ah = vld_q[REQ_AH];
    assign rd_valid_fc = vld_q[REQ_FC];
    assign rd_data_o   = data_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_addr    = addr_q;
    assign cmd_len     = len_q;
    assign err_stray   = err_q;

endmodule

// File: doc/weight_rd_arbiter.md
Name: weight_rd_arbiter

Overview:
- Shares the single weight-fetch read channel (SPI flash/FIFO front end) between two requesters: the LSTM a/h gate-calculation engine (AH) and the FC matrix-vector engine (FC).
- Each requester asks for a burst of weight words at an address. The arbiter grants one requester at a time, round-robin, and issues one command to the fetch engine.
- It routes returned beats to the granted requester and pulses done on the last beat.
- It replaces the ad-hoc rd_busy/ahcal_busy interlock between the two engines.

Parameters:
- QZ, 16, weight quantisation width
- DATA_W, QZ*4, read beat width (four gate weights per beat)
- ADDR_W, 20, weight address width (512*512*4 words)
- LEN_W, 10, burst length width in beats (max 1023)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_ah  in  1  AH burst request; level, held until done_ah
- addr_ah  in  ADDR_W  AH start address; sampled at grant
- len_ah  in  LEN_W  AH beat count; sampled at grant
- req_fc  in  1  FC burst request; level, held until done_fc
- addr_fc  in  ADDR_W  FC start address
- len_fc  in  LEN_W  FC beat count
- gnt_ah  out  1  AH owns the channel
- gnt_fc  out  1  FC owns the channel
- done_ah  out  1  one-cycle pulse on the last AH beat
- done_fc  out  1  one-cycle pulse on the last FC beat
- rd_valid_ah  out  1  beat valid for AH
- rd_valid_fc  out  1  beat valid for FC
- rd_data_o  out  DATA_W  registered beat data, shared by both requesters
- cmd_valid  out  1  command to fetch engine
- cmd_addr  out  ADDR_W  command address
- cmd_len  out  LEN_W  command beat count
- cmd_ready  in  1  fetch engine accepts command
- rd_data  in  DATA_W  beat from fetch engine
- rd_valid  in  1  beat valid from fetch engine
- err_stray  out  1  sticky: beat arrived with no burst outstanding

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Every output is 0 and the state is IDLE.
  - Priority pointer selects AH.
  - The beat counter and latched address/length are cleared.
- States: IDLE, CMD, XFER, GAP.
- IDLE:
  - If either request is present, the winner is picked and the state moves to CMD on the next edge.
  - The matching gnt is set, the winner's addr and len are latched, and cmd_valid is raised (all registered).
  - Latency from req to gnt/cmd_valid is 1 cycle.
- Winner selection:
  - With a single request, that requester wins.
  - With simultaneous requests, the requester not served last wins. After reset this is AH.
- CMD:
  - cmd_valid, cmd_addr and cmd_len are held stable until cmd_ready=1, then the state moves to XFER and cmd_valid drops the next cycle.
  - If the latched len is 0, no command is issued: done pulses next cycle and the state moves to GAP.
- XFER:
  - Each rd_valid registers rd_data into rd_data_o and asserts rd_valid_<gnt> for 1 cycle. Latency is 1 cycle; the other requester's rd_valid stays 0.
  - Beats are counted. On the beat where count reaches len, done_<gnt> pulses in the same cycle as that beat's rd_valid_<gnt>, and the state moves to GAP.
- GAP (1 cycle):
  - gnt drops and the priority pointer toggles to the other requester.
  - Next state is IDLE. New requests are not evaluated in GAP, so back-to-back grants are spaced 2 cycles apart.
- Grant stability:
  - gnt never changes during CMD or XFER.
  - A req dropped mid-burst is ignored; the burst completes and done still pulses.
- Stray beats:
  - A rd_valid in IDLE, CMD or GAP is dropped and sets err_stray.
  - err_stray clears only on reset.
- Reset mid-burst: the burst is abandoned with no done pulse. Beats still arriving afterwards are strays.
- Widths:
  - The beat counter is LEN_W bits and is never compared past len.
  - rd_data_o passes through unmodified.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CMD, XFER, GAP)
  - QZ, DATA_W, ADDR_W, LEN_W defaults
  - requester index constants (REQ_AH=0, REQ_FC=1)
- One sub-module, rr_arb2:
  - two-way round-robin pick from req[1:0] plus priority pointer
  - one-hot grant, combinational
  - pointer register stays in the parent

Test Plan:
- Reset, then req_ah=1 with addr_ah=0x00400, len_ah=4 and cmd_ready=1 at once, 4 beats sent → gnt_ah at cycle 1; cmd_addr=0x00400, cmd_len=4; rd_valid_ah ×4; done_ah on the 4th; gnt_ah low after GAP.
- req_ah and req_fc both high from reset, each len=2 → AH served first, then FC; then re-raise both → AH served again. Grants alternate; gnt_ah and gnt_fc are never high together.
- cmd_ready held low for 5 cycles during CMD → cmd_valid and cmd_addr stable all 5 cycles; no rd_valid_* output; transfer proceeds after cmd_ready.
- len_fc=0 request → no cmd_valid, done_fc pulses 1 cycle after grant, and the pointer toggles.
- rd_valid pulsed while IDLE → no rd_valid_ah or rd_valid_fc; err_stray=1 and stays set until rst.
- rst asserted mid-XFER after 2 of 8 beats → all outputs 0 next cycle; no done; a subsequent beat sets err_stray; a new req_fc is granted normally.
